// File: rtl/lbp_win_sched.sv
// Window-fetch and write-back scheduler for the LBP engine: walks the interior pixels,
// gathers each 3x3 window from gray memory and writes the returned code with a clean strobe.
module lbp_win_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] gray_addr,
  output logic          gray_req,
  input  logic [7:0]    gray_data,
  output logic [71:0]   win_data,
  output logic          win_valid,
  input  logic          win_ready,
  input  logic          res_valid,
  input  logic [7:0]    res_data,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          lbp_write,
  output logic          busy,
  output logic          finish
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_FULL,
    S_FETCH_COL,
    S_DRAIN,
    S_PRESENT,
    S_RESULT,
    S_WR_SETUP,
    S_WR_PULSE,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] W_L    = AW'(IMG_W);
  localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 2);
  localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 2);
  localparam logic [AW-1:0] ONE_L  = AW'(1);

  state_t        state_q;
  logic [AW-1:0] x_q;
  logic [AW-1:0] y_q;
  logic [1:0]    r_q;
  logic [1:0]    c_q;
  logic [3:0]    k_q;
  logic          cap_vld_q;
  logic [3:0]    cap_k_q;
  logic [7:0]    win_q [0:8];
  logic [AW-1:0] gray_addr_q;
  logic          gray_req_q;
  logic          win_valid_q;
  logic [AW-1:0] lbp_addr_q;
  logic [7:0]    lbp_data_q;
  logic          lbp_write_q;
  logic          busy_q;
  logic          finish_q;

  logic [AW-1:0] r_ext;
  logic [AW-1:0] c_ext;
  logic [AW-1:0] rd_addr_d;
  logic [AW-1:0] pix_addr_d;

  always_comb begin
    r_ext      = '0;
    c_ext      = '0;
    r_ext[1:0] = r_q;
    c_ext[1:0] = c_q;
    rd_addr_d  = (y_q + r_ext - ONE_L) * W_L + x_q + c_ext - ONE_L;
    pix_addr_d = y_q * W_L + x_q;
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_pack
    assign win_data[8*gi +: 8] = win_q[gi];
  end

  assign gray_addr = gray_addr_q;
  assign gray_req  = gray_req_q;
  assign win_valid = win_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign lbp_write = lbp_write_q;
  assign busy      = busy_q;
  assign finish    = finish_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      cap_vld_q   <= 1'b0;
      cap_k_q     <= '0;
      for (int wi = 0; wi < 9; wi++) win_q[wi] <= '0;
      gray_addr_q <= '0;
      gray_req_q  <= 1'b0;
      win_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      lbp_write_q <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      // Request and capture tag default low; only fetch states re-arm them.
      gray_req_q <= 1'b0;
      cap_vld_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            finish_q <= 1'b0;
            busy_q   <= 1'b1;
            x_q      <= ONE_L;
            y_q      <= ONE_L;
            r_q      <= 2'd0;
            c_q      <= 2'd0;
            k_q      <= 4'd0;
            state_q  <= S_FETCH_FULL;
          end
        end

        S_FETCH_FULL: begin
          gray_addr_q <= rd_addr_d;
          gray_req_q  <= 1'b1;
          cap_vld_q   <= 1'b1;
          cap_k_q     <= k_q;
          if (c_q == 2'd2) begin
            c_q <= 2'd0;
            r_q <= r_q + 2'd1;
          end else begin
            c_q <= c_q + 2'd1;
          end
          k_q <= k_q + 4'd1;
          if (k_q == 4'd8) state_q <= S_DRAIN;
        end

        S_FETCH_COL: begin
          // Slide the window one column left before the new right column lands.
          if (k_q == 4'd2) begin
            for (int ri = 0; ri < 3; ri++) begin
              win_q[3*ri]   <= win_q[3*ri+1];
              win_q[3*ri+1] <= win_q[3*ri+2];
            end
          end
          gray_addr_q <= rd_addr_d;
          gray_req_q  <= 1'b1;
          cap_vld_q   <= 1'b1;
          cap_k_q     <= k_q;
          r_q         <= r_q + 2'd1;
          k_q         <= k_q + 4'd3;
          if (k_q == 4'd8) state_q <= S_DRAIN;
        end

        S_DRAIN: begin
          win_valid_q <= 1'b1;
          state_q     <= S_PRESENT;
        end

        S_PRESENT: begin
          if (win_ready) begin
            win_valid_q <= 1'b0;
            state_q     <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (res_valid) begin
            lbp_data_q <= res_data;
            lbp_addr_q <= pix_addr_d;
            state_q    <= S_WR_SETUP;
          end
        end

        S_WR_SETUP: begin
          lbp_write_q <= 1'b1;
          state_q     <= S_WR_PULSE;
        end

        S_WR_PULSE: begin
          lbp_write_q <= 1'b0;
          if (x_q < X_LAST) begin
            x_q     <= x_q + ONE_L;
            r_q     <= 2'd0;
            c_q     <= 2'd2;
            k_q     <= 4'd2;
            state_q <= S_FETCH_COL;
          end else if (y_q < Y_LAST) begin
            x_q     <= ONE_L;
            y_q     <= y_q + ONE_L;
            r_q     <= 2'd0;
            c_q     <= 2'd0;
            k_q     <= 4'd0;
            state_q <= S_FETCH_FULL;
          end else begin
            finish_q <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      // Data for a read registered on the previous edge is on gray_data now.
      if (cap_vld_q) win_q[cap_k_q] <= gray_data;
    end
  end

endmodule

// File: tb/tb_lbp_win_sched.sv
// Directed bench for lbp_win_sched: memory and compute-unit models around the scheduler,
// one task per scenario with inline expected-value checks.
`timescale 1ns/1ps
module tb_lbp_win_sched;

  localparam int AW = 6;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic [7:0]    gray_data = 8'h00;
  logic [71:0]   win_data;
  logic          win_valid;
  logic          win_ready;
  logic          res_valid;
  logic [7:0]    res_data;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          lbp_write;
  logic          busy;
  logic          finish;

  lbp_win_sched #(.IMG_W(8), .IMG_H(8), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .gray_addr(gray_addr), .gray_req(gray_req), .gray_data(gray_data),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .res_valid(res_valid), .res_data(res_data),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .lbp_write(lbp_write),
    .busy(busy), .finish(finish)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] gmem [0:63];
  logic [7:0] lbp_mem [0:63];
  int wr_cnt = 0;
  int wr_addr_log [0:127];
  int wr_data_log [0:127];
  int wr_cyc_log [0:127];
  int trace [0:127];
  int trace_n = 0;
  bit trace_en = 1'b0;
  bit prev_req = 1'b0;

  // Compute-unit model configuration.
  int ready_hold = 0;
  int res_lat = 1;
  bit stray_en = 1'b0;
  bit early_en = 1'b0;
  int wait_cnt = 0;
  int res_cnt = 0;
  logic [7:0] res_hold = 8'h00;

  initial forever begin
    @(negedge clk);
    cyc++;
  end

  // Gray memory: value = address, loaded on the negedge after a request.
  initial begin
    for (int i = 0; i < 64; i++) gmem[i] = 8'(i);
    forever begin
      @(negedge clk);
      if (gray_req) gray_data = gmem[gray_addr];
    end
  end

  // Compute unit: echoes window byte 4 res_lat cycles after acceptance.
  initial begin
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = 8'h00;
    forever begin
      @(negedge clk);
      win_ready = 1'b0;
      res_valid = 1'b0;
      if (reset) begin
        wait_cnt = 0;
        res_cnt  = 0;
      end else begin
        if (res_cnt > 0) begin
          res_cnt--;
          if (res_cnt == 0) begin
            res_valid = 1'b1;
            res_data  = res_hold;
          end
        end
        if (stray_en && gray_req) begin
          res_valid = 1'b1;
          res_data  = 8'hEE;
        end
        if (win_valid) begin
          if (wait_cnt >= ready_hold) begin
            win_ready = 1'b1;
            res_hold  = win_data[39:32];
            res_cnt   = res_lat;
            wait_cnt  = 0;
            if (early_en) begin
              res_valid = 1'b1;
              res_data  = 8'hDD;
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // LBP memory: captures on the rising edge of the strobe.
  initial forever begin
    @(posedge lbp_write);
    if (wr_cnt < 128) begin
      wr_addr_log[wr_cnt] = int'(lbp_addr);
      wr_data_log[wr_cnt] = int'(lbp_data);
      wr_cyc_log[wr_cnt]  = cyc;
    end
    lbp_mem[lbp_addr] = lbp_data;
    wr_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (trace_en && trace_n < 120) begin
      if (gray_req) begin
        trace[trace_n] = int'(gray_addr);
        trace_n++;
      end else if (prev_req) begin
        trace[trace_n] = 255;
        trace_n++;
      end
    end
    prev_req = gray_req;
  end

  task automatic clear_logs();
    wr_cnt = 0;
    for (int i = 0; i < 64; i++) lbp_mem[i] = 8'h00;
    for (int i = 0; i < 128; i++) begin
      wr_addr_log[i] = -1;
      wr_data_log[i] = -1;
      trace[i] = -1;
    end
    trace_n = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (finish) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (gray_addr !== 6'd0) begin n_bad++; $display("FAIL reset_gray_addr: got %0d want 0", gray_addr); end
    n_cmp++; if (gray_req !== 1'b0) begin n_bad++; $display("FAIL reset_gray_req: got %b want 0", gray_req); end
    n_cmp++; if (win_data !== 72'd0) begin n_bad++; $display("FAIL reset_win_data: got %h want 0", win_data); end
    n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
    n_cmp++; if (lbp_addr !== 6'd0) begin n_bad++; $display("FAIL reset_lbp_addr: got %0d want 0", lbp_addr); end
    n_cmp++; if (lbp_data !== 8'd0) begin n_bad++; $display("FAIL reset_lbp_data: got %0d want 0", lbp_data); end
    n_cmp++; if (lbp_write !== 1'b0) begin n_bad++; $display("FAIL reset_lbp_write: got %b want 0", lbp_write); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", finish); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    $display("reset: outputs checked");
  endtask

  task automatic test_full_image();
    bit to;
    int exp_tr [0:29];
    int n = 0;
    int setup_bad = 0;
    int border_bad = 0;
    int interior_bad = 0;
    bit prev_lw = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [7:0] prev_d = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin exp_tr[n] = r*8 + c; n++; end
    exp_tr[n] = 255; n++;
    for (int x = 2; x <= 6; x++) begin
      for (int r = 0; r < 3; r++) begin exp_tr[n] = r*8 + x + 1; n++; end
      exp_tr[n] = 255; n++;
    end
    clear_logs();
    ready_hold = 0; res_lat = 1; stray_en = 0; early_en = 0;
    trace_en = 1'b1;
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (lbp_write && !prev_lw && (lbp_addr !== prev_a || lbp_data !== prev_d)) setup_bad++;
      if (!lbp_write && prev_lw && (lbp_addr !== prev_a || lbp_data !== prev_d)) setup_bad++;
      prev_lw = lbp_write; prev_a = lbp_addr; prev_d = lbp_data;
      if (finish) begin to = 1'b0; break; end
    end
    trace_en = 1'b0;
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL full_timeout: finish not seen within %0d cycles", LIMIT); end
    n_cmp++; if (wr_cnt !== 36) begin n_bad++; $display("FAIL full_write_count: got %0d want 36", wr_cnt); end
    for (int i = 0; i < 36; i++) begin
      int ea;
      ea = (1 + i/6)*8 + 1 + i%6;
      n_cmp++; if (wr_addr_log[i] !== ea) begin n_bad++; $display("FAIL full_wr_addr[%0d]: got %0d want %0d", i, wr_addr_log[i], ea); end
      n_cmp++; if (wr_data_log[i] !== ea) begin n_bad++; $display("FAIL full_wr_data[%0d]: got %0d want %0d", i, wr_data_log[i], ea); end
    end
    for (int a = 0; a < 64; a++) begin
      if (a%8 == 0 || a%8 == 7 || a/8 == 0 || a/8 == 7) begin
        if (lbp_mem[a] !== 8'd0) border_bad++;
      end else if (lbp_mem[a] !== 8'(a)) interior_bad++;
    end
    n_cmp++; if (border_bad !== 0) begin n_bad++; $display("FAIL full_border: got %0d nonzero border entries want 0", border_bad); end
    n_cmp++; if (interior_bad !== 0) begin n_bad++; $display("FAIL full_interior: got %0d wrong interior entries want 0", interior_bad); end
    n_cmp++; if (setup_bad !== 0) begin n_bad++; $display("FAIL full_strobe_setup: got %0d addr/data changes at strobe edges want 0", setup_bad); end
    n_cmp++; if (wr_cyc_log[1] - wr_cyc_log[0] !== 8) begin n_bad++; $display("FAIL full_col_period: got %0d want 8", wr_cyc_log[1] - wr_cyc_log[0]); end
    n_cmp++; if (wr_cyc_log[6] - wr_cyc_log[5] !== 14) begin n_bad++; $display("FAIL full_row_period: got %0d want 14", wr_cyc_log[6] - wr_cyc_log[5]); end
    for (int i = 0; i < 30; i++) begin
      n_cmp++; if (trace[i] !== exp_tr[i]) begin n_bad++; $display("FAIL full_read_trace[%0d]: got %0d want %0d", i, trace[i], exp_tr[i]); end
    end
    n_cmp++; if (finish !== 1'b1) begin n_bad++; $display("FAIL full_finish: got %b want 1", finish); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_after: got %b want 0", busy); end
    $display("full_image: %0d writes, %0d trace entries", wr_cnt, trace_n);
  endtask

  task automatic test_start_busy();
    bit to;
    repeat (5) @(negedge clk);
    n_cmp++; if (finish !== 1'b1) begin n_bad++; $display("FAIL hold_finish: got %b want 1", finish); end
    clear_logs();
    pulse_start();
    n_cmp++; if (finish !== 1'b0) begin n_bad++; $display("FAIL start_clears_finish: got %b want 0", finish); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_sets_busy: got %b want 1", busy); end
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (150) @(negedge clk);
    pulse_start();
    wait_finish(to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL busy_start_timeout: finish not seen within %0d cycles", LIMIT); end
    n_cmp++; if (wr_cnt !== 36) begin n_bad++; $display("FAIL busy_start_write_count: got %0d want 36", wr_cnt); end
    repeat (6) @(negedge clk);
    n_cmp++; if (finish !== 1'b1) begin n_bad++; $display("FAIL finish_sticky: got %b want 1", finish); end
    n_cmp++; if (wr_cnt !== 36) begin n_bad++; $display("FAIL no_restart: got %0d writes want 36", wr_cnt); end
    $display("start_busy: %0d writes, finish=%b", wr_cnt, finish);
  endtask

  task automatic test_backpressure();
    int hold_bad = 0;
    int req_bad = 0;
    int valid_cyc = 0;
    bit to = 1'b1;
    bit prev_v = 1'b0;
    logic [71:0] prev_w = '0;
    clear_logs();
    ready_hold = 5; res_lat = 1; stray_en = 0; early_en = 0;
    pulse_start();
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (win_valid) begin
        valid_cyc++;
        if (prev_v && win_data !== prev_w) hold_bad++;
        if (gray_req) req_bad++;
      end
      prev_v = win_valid;
      prev_w = win_data;
      if (finish) begin to = 1'b0; break; end
    end
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: finish not seen within %0d cycles", LIMIT); end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL bp_win_stable: got %0d changes want 0", hold_bad); end
    n_cmp++; if (req_bad !== 0) begin n_bad++; $display("FAIL bp_no_reads: got %0d reads while valid want 0", req_bad); end
    n_cmp++; if (valid_cyc !== 216) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want 216", valid_cyc); end
    n_cmp++; if (wr_cnt !== 36) begin n_bad++; $display("FAIL bp_write_count: got %0d want 36", wr_cnt); end
    ready_hold = 0;
    $display("backpressure: %0d valid cycles, %0d writes", valid_cyc, wr_cnt);
  endtask

  task automatic test_delayed_result();
    bit to;
    int bad = 0;
    clear_logs();
    ready_hold = 0; res_lat = 7; stray_en = 1; early_en = 1;
    pulse_start();
    wait_finish(to);
    stray_en = 0; early_en = 0; res_lat = 1;
    for (int i = 0; i < 36; i++) begin
      int ea;
      ea = (1 + i/6)*8 + 1 + i%6;
      if (wr_addr_log[i] !== ea || wr_data_log[i] !== ea) bad++;
    end
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL delay_timeout: finish not seen within %0d cycles", LIMIT); end
    n_cmp++; if (wr_cnt !== 36) begin n_bad++; $display("FAIL delay_write_count: got %0d want 36", wr_cnt); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL delay_write_content: got %0d wrong writes want 0", bad); end
    n_cmp++; if (wr_cyc_log[1] - wr_cyc_log[0] !== 14) begin n_bad++; $display("FAIL delay_col_period: got %0d want 14", wr_cyc_log[1] - wr_cyc_log[0]); end
    $display("delayed_result: %0d writes, %0d bad", wr_cnt, bad);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit to;
    int interior_bad = 0;
    clear_logs();
    ready_hold = 0; res_lat = 1;
    pulse_start();
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (busy && lbp_addr == 6'd34 && !lbp_write) begin found = 1'b1; break; end
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rmid_found_setup: got %b want 1", found); end
    n_cmp++; if ({gray_addr, gray_req, win_data, win_valid, lbp_addr, lbp_data, lbp_write, busy, finish} !== 97'd0) begin
      n_bad++; $display("FAIL rmid_outputs: got %h want 0", {gray_addr, gray_req, win_data, win_valid, lbp_addr, lbp_data, lbp_write, busy, finish});
    end
    n_cmp++; if (wr_cnt !== 19) begin n_bad++; $display("FAIL rmid_no_write: got %0d writes want 19", wr_cnt); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cnt !== 19) begin n_bad++; $display("FAIL rmid_quiet: got %0d writes want 19", wr_cnt); end
    clear_logs();
    pulse_start();
    wait_finish(to);
    for (int a = 0; a < 64; a++)
      if (!(a%8 == 0 || a%8 == 7 || a/8 == 0 || a/8 == 7) && lbp_mem[a] !== 8'(a)) interior_bad++;
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rmid_timeout: finish not seen within %0d cycles", LIMIT); end
    n_cmp++; if (wr_cnt !== 36) begin n_bad++; $display("FAIL rmid_write_count: got %0d want 36", wr_cnt); end
    n_cmp++; if (interior_bad !== 0) begin n_bad++; $display("FAIL rmid_interior: got %0d wrong entries want 0", interior_bad); end
    n_cmp++; if (finish !== 1'b1) begin n_bad++; $display("FAIL rmid_finish: got %b want 1", finish); end
    $display("reset_mid: rerun %0d writes, finish=%b", wr_cnt, finish);
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_full_image();
    test_start_busy();
    test_backpressure();
    test_delayed_result();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lbp_win_sched.md
# lbp_win_sched

Window-fetch and write-back scheduler for the LBP engine. It walks every interior pixel of the gray image, reads the 3x3 neighbourhood from gray memory with sliding-column reuse, and hands the 72-bit window to the LBP compute datapath over a valid/ready handshake. It then writes the 8-bit result to LBP memory with a glitch-free write pulse. It sits between `gray_mem`/`lbp_mem` and the compute unit and owns all memory sequencing and `finish`.

## Interface
- `IMG_W`, default 8: image width in pixels.
- `IMG_H`, default 8: image height in pixels.
- `AW`, default 6: memory address width; IMG_W*IMG_H must be at most 2^AW.
- `clk` in 1: sole clock. All outputs are registered on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to process the image; sampled only in IDLE.
- `gray_addr` out AW: gray memory read address.
- `gray_req` out 1: read enable. Memory loads `gray_data` on the following negedge.
- `gray_data` in 8: read data, valid at the posedge after the issuing posedge.
- `win_data` out 72: window; byte k = [8k+7:8k], k = 3r+c, with r, c row/column offsets 0..2; k=4 is centre.
- `win_valid` out 1: window valid.
- `win_ready` in 1: compute unit accepts the window.
- `res_valid` in 1: result valid.
- `res_data` in 8: LBP code.
- `lbp_addr` out AW: LBP memory write address.
- `lbp_data` out 8: LBP memory write data.
- `lbp_write` out 1: write strobe. Memory captures on the rising edge of this strobe.
- `busy` out 1: high in every state except IDLE.
- `finish` out 1: image complete; held until the next accepted start or reset.

## Operation
- Interior pixels only: y = 1..IMG_H-2, x = 1..IMG_W-2, raster order. Border locations are never written.
- Read address for byte k is (y-1+r)*IMG_W + (x-1+c).
- States:
  - IDLE: `start` → FETCH_FULL; clear `finish`, set x=y=1.
  - FETCH_FULL: used when x=1. Issue 9 reads, one per cycle, k = 0..8. Go to DRAIN.
  - FETCH_COL: used when x>1. First shift the window: byte 3r+0 ← 3r+1, byte 3r+1 ← 3r+2. Then issue 3 reads for k = 2, 5, 8. Go to DRAIN.
  - DRAIN: one cycle capturing the last read → PRESENT.
  - PRESENT: `win_valid`=1; on `win_ready` → RESULT.
  - RESULT: on `res_valid`, latch `res_data` into `lbp_data`, set `lbp_addr` = y*IMG_W + x → WR_SETUP.
  - WR_SETUP: `lbp_write`=0; address and data stable → WR_PULSE.
  - WR_PULSE: `lbp_write`=1 for exactly one cycle, address and data held. Then:
    - x < IMG_W-2 → FETCH_COL with x+1;
    - otherwise, if y < IMG_H-2 → FETCH_FULL with x=1, y+1;
    - otherwise → DONE.
  - DONE: `finish`=1 → IDLE; `finish` stays 1.
- Every read issued in cycle n is captured into the window byte at the end of cycle n+1. The capture pipeline carries the target k with each read.
- `gray_req` is 1 only during FETCH_* cycles. `gray_addr` holds its last value otherwise.
- `start` outside IDLE is ignored.
- `win_ready` outside PRESENT is ignored.
- `res_valid` outside RESULT is ignored, including a result arriving early in the same cycle as acceptance.

## Timing
- Reset values: `gray_addr`=0, `gray_req`=0, `win_data`=0, `win_valid`=0, `lbp_addr`=0, `lbp_data`=0, `lbp_write`=0, `busy`=0, `finish`=0, state IDLE.
- Reset mid-operation returns to IDLE next cycle. There is no partial write: `lbp_write` drops the same cycle.
- Read latency is exactly 1 cycle (registered address at posedge P0, negedge load, capture at P1).
- `win_valid` stays high, with `win_data` stable, until the cycle `win_ready` is sampled high. It deasserts the next cycle.
- The write strobe rises one full cycle after `lbp_addr`/`lbp_data` change, and falls one cycle before they may change.
- Minimum cycles per pixel (`win_ready` already high, `res_valid` one cycle after acceptance):
  - full fetch: 9+1+1+1+1+1 = 14;
  - column fetch: 3+1+1+1+1+1 = 8.
- `finish` rises one cycle after the last WR_PULSE.

## Test plan
- Default 8x8 image with value = address, compute unit echoing `win_data` byte 4:
  - exactly 36 writes, each with `lbp_data` = `lbp_addr`;
  - addresses 9..14, 17..22, ..., 49..54 in order;
  - border entries stay 0.
- Read trace for row y=1:
  - reads 0,1,2,8,9,10,16,17,18;
  - then 3,11,19 for x=2;
  - ...;
  - then 7,15,23 for x=6;
  - `gray_req` low between groups.
- Backpressure: `win_ready` low for 5 cycles → `win_valid` and `win_data` constant throughout; no reads issued; exactly one write per pixel.
- Delayed result: `res_valid` arrives 7 cycles after acceptance; a stray `res_valid` pulse during FETCH is ignored → write count unchanged at 36.
- Reset asserted during WR_SETUP of pixel 20 → outputs at reset values next cycle, no `lbp_write` edge. A fresh `start` then completes all 36 writes and `finish`=1.
- `start` pulsed while busy → ignored. `finish` stays 1 after completion until the next `start`, then clears in the same cycle the start is accepted.
